// File: rtl/axis_packet_gen.sv
// ---------------------------------------------------------------------------
// axis_packet_gen
//
// AXI-Stream packet source. Each accepted start request emits one packet of
// pkt_len bytes. Payload byte i is (first_byte + i) mod 256. Bytes are packed
// little-endian: lane k of a beat carries payload byte beat_index*BYTES + k.
// The final beat qualifies its valid lanes with tkeep, drives unused lanes
// to zero and asserts tlast.
//
// Handshake: a beat transfers on a rising edge where tvalid && tready.
// tvalid never depends on tready. While tvalid=1 and tready=0, every stream
// output holds its value.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   start          in   packet request, sampled only in IDLE
//   pkt_len        in   packet length in bytes (0 = request ignored)
//   first_byte     in   value of payload byte 0
//   busy           out  high while a packet is in progress (SEND state)
//   done           out  one-cycle pulse in the cycle after the last handshake
//   m_axis_tready  in   sink ready
//   m_axis_tvalid  out  beat valid
//   m_axis_tdata   out  beat data
//   m_axis_tkeep   out  byte-lane qualifiers
//   m_axis_tlast   out  last beat of the packet
// ---------------------------------------------------------------------------
module axis_packet_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    pkt_len,
    input  logic [7:0]              first_byte,
    output logic                    busy,
    output logic                    done,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast
);

    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  r_state;
    logic [LEN_WIDTH-1:0]    r_bytes_left;  // bytes remaining, counted from the beat on the bus
    logic [7:0]              r_next_byte;   // payload value in lane 0 of the beat on the bus
    logic                    r_tvalid;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic [BYTES-1:0]        r_tkeep;
    logic                    r_tlast;
    logic                    r_done;

    logic                    w_load;
    logic                    w_hs;
    logic [LEN_WIDTH-1:0]    w_src_len;
    logic [7:0]              w_src_byte;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [BYTES-1:0]        w_keep;
    logic                    w_last;

    // The next beat is built from one of two sources. On a new packet it
    // comes from the request inputs. Otherwise it comes from the counters
    // advanced past the beat currently on the bus. The whole beat is then
    // registered, so tdata/tkeep/tlast come straight from flops.
    always_comb begin
        w_load     = (r_state == ST_IDLE) && start && (pkt_len != '0);
        w_hs       = r_tvalid && m_axis_tready;
        w_src_len  = w_load ? pkt_len    : (r_bytes_left - LEN_WIDTH'(BYTES));
        w_src_byte = w_load ? first_byte : (r_next_byte + 8'(BYTES));
        w_data     = '0;
        w_keep     = '0;
        for (int k = 0; k < BYTES; k++) begin
            w_keep[k] = (LEN_WIDTH'(k) < w_src_len);
            w_data[8*k +: 8] = w_keep[k] ? (w_src_byte + 8'(k)) : 8'h00;
        end
        w_last = (w_src_len <= LEN_WIDTH'(BYTES));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bytes_left <= '0;
            r_next_byte  <= '0;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tlast      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state      <= ST_SEND;
                        r_bytes_left <= w_src_len;
                        r_next_byte  <= w_src_byte;
                        r_tvalid     <= 1'b1;
                        r_tdata      <= w_data;
                        r_tkeep      <= w_keep;
                        r_tlast      <= w_last;
                    end
                end
                ST_SEND: begin
                    // Without a handshake nothing changes, which holds the
                    // beat stable under backpressure.
                    if (w_hs) begin
                        if (r_tlast) begin
                            r_state      <= ST_IDLE;
                            r_bytes_left <= '0;
                            r_next_byte  <= '0;
                            r_tvalid     <= 1'b0;
                            r_tdata      <= '0;
                            r_tkeep      <= '0;
                            r_tlast      <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_bytes_left <= w_src_len;
                            r_next_byte  <= w_src_byte;
                            r_tdata      <= w_data;
                            r_tkeep      <= w_keep;
                            r_tlast      <= w_last;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = (r_state == ST_SEND);
    assign done          = r_done;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;

endmodule

// File: tb/tb_axis_packet_gen.sv
// ---------------------------------------------------------------------------
// tb_axis_packet_gen
//
// Directed bench for axis_packet_gen with DATA_WIDTH=32. Inputs change 1 ns
// after each rising edge. Outputs are checked at the same point, so each
// check sees the registers loaded by the preceding edge.
// ---------------------------------------------------------------------------
module tb_axis_packet_gen;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [LW-1:0] pkt_len;
    logic [7:0]    first_byte;
    logic          busy;
    logic          done;
    logic          m_axis_tready;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic          m_axis_tlast;

    int n_cmp  = 0;
    int n_fail = 0;

    axis_packet_gen #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pkt_len       (pkt_len),
        .first_byte    (first_byte),
        .busy          (busy),
        .done          (done),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] data,
                               input logic [3:0] keep, input logic last);
        chk({tag, "_valid"}, 32'(m_axis_tvalid), 32'd1);
        chk({tag, "_busy"},  32'(busy),          32'd1);
        chk({tag, "_data"},  m_axis_tdata,       data);
        chk({tag, "_keep"},  32'(m_axis_tkeep),  32'(keep));
        chk({tag, "_last"},  32'(m_axis_tlast),  32'(last));
        chk({tag, "_done"},  32'(done),          32'd0);
    endtask

    task automatic expect_idle(input string tag, input logic exp_done);
        chk({tag, "_valid"}, 32'(m_axis_tvalid), 32'd0);
        chk({tag, "_busy"},  32'(busy),          32'd0);
        chk({tag, "_last"},  32'(m_axis_tlast),  32'd0);
        chk({tag, "_done"},  32'(done),          32'(exp_done));
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        pkt_len       = '0;
        first_byte    = '0;
        m_axis_tready = 1'b1;

        // Reset state.
        step();
        chk("rst_data", m_axis_tdata, 32'h0);
        chk("rst_keep", 32'(m_axis_tkeep), 32'h0);
        expect_idle("rst", 1'b0);
        reset = 1'b0;
        step();
        expect_idle("post_rst", 1'b0);

        // 10 bytes from 0x10 with tready always high.
        start = 1'b1; pkt_len = 16'd10; first_byte = 8'h10;
        step();
        start = 1'b0;
        expect_beat("p1_b0", 32'h13121110, 4'hF, 1'b0);
        step();
        expect_beat("p1_b1", 32'h17161514, 4'hF, 1'b0);
        step();
        expect_beat("p1_b2", 32'h00001918, 4'h3, 1'b1);
        step();
        expect_idle("p1_done", 1'b1);
        step();
        expect_idle("p1_after", 1'b0);

        // Same packet with tready per cycle 1,0,0,1,0,1.
        m_axis_tready = 1'b1;
        start = 1'b1; pkt_len = 16'd10; first_byte = 8'h10;
        step();
        start = 1'b0;
        expect_beat("bp_b0", 32'h13121110, 4'hF, 1'b0);
        m_axis_tready = 1'b1;
        step();
        expect_beat("bp_b1", 32'h17161514, 4'hF, 1'b0);
        m_axis_tready = 1'b0;
        step();
        expect_beat("bp_b1_hold1", 32'h17161514, 4'hF, 1'b0);
        m_axis_tready = 1'b0;
        step();
        expect_beat("bp_b1_hold2", 32'h17161514, 4'hF, 1'b0);
        m_axis_tready = 1'b1;
        step();
        expect_beat("bp_b2", 32'h00001918, 4'h3, 1'b1);
        m_axis_tready = 1'b0;
        step();
        expect_beat("bp_b2_hold", 32'h00001918, 4'h3, 1'b1);
        m_axis_tready = 1'b1;
        step();
        expect_idle("bp_done", 1'b1);
        step();

        // Exact-fit single beat with byte wraparound.
        start = 1'b1; pkt_len = 16'd4; first_byte = 8'hFE;
        step();
        start = 1'b0;
        expect_beat("wrap_b0", 32'h0100FFFE, 4'hF, 1'b1);
        step();
        expect_idle("wrap_done", 1'b1);
        step();

        // Zero-length request is ignored.
        start = 1'b1; pkt_len = 16'd0; first_byte = 8'h55;
        step();
        expect_idle("zero_1", 1'b0);
        step();
        expect_idle("zero_2", 1'b0);
        start = 1'b0;
        step();
        expect_idle("zero_3", 1'b0);

        // start held high: one idle gap between packets, and request inputs
        // changed mid-packet only affect the next packet.
        start = 1'b1; pkt_len = 16'd8; first_byte = 8'h00;
        step();
        pkt_len = 16'd4; first_byte = 8'h40;
        expect_beat("bb_p1_b0", 32'h03020100, 4'hF, 1'b0);
        step();
        expect_beat("bb_p1_b1", 32'h07060504, 4'hF, 1'b1);
        step();
        expect_idle("bb_gap", 1'b1);
        step();
        start = 1'b0;
        expect_beat("bb_p2_b0", 32'h43424140, 4'hF, 1'b1);
        step();
        expect_idle("bb_p2_done", 1'b1);
        step();

        // Reset in the middle of a 12-byte packet.
        start = 1'b1; pkt_len = 16'd12; first_byte = 8'h20;
        step();
        start = 1'b0;
        expect_beat("mr_b0", 32'h23222120, 4'hF, 1'b0);
        step();
        expect_beat("mr_b1", 32'h27262524, 4'hF, 1'b0);
        #2 reset = 1'b1;
        #1;
        expect_idle("mr_async", 1'b0);
        step();
        reset = 1'b0;
        step();
        expect_idle("mr_released", 1'b0);
        start = 1'b1; pkt_len = 16'd12; first_byte = 8'h20;
        step();
        start = 1'b0;
        expect_beat("mr_new_b0", 32'h23222120, 4'hF, 1'b0);
        step();
        expect_beat("mr_new_b1", 32'h27262524, 4'hF, 1'b0);
        step();
        expect_beat("mr_new_b2", 32'h2B2A2928, 4'hF, 1'b1);
        step();
        expect_idle("mr_new_done", 1'b1);
        step();
        expect_idle("mr_new_after", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_packet_gen.md
# axis_packet_gen

Source-side AXI-Stream packet generator: drives the slave side of the stream FIFO and any other AXI-Stream sink in the design. It emits one packet per start request, with a programmable byte length and an incrementing-byte payload. Packing is little-endian. On the last beat it drives tkeep for the partial beat and asserts tlast. It honours tready backpressure and is the stimulus/traffic source paired with the FIFO path.

## Interface
- DATA_WIDTH, 8: stream data width in bits; multiple of 8. BYTES = DATA_WIDTH/8.
- LEN_WIDTH, 16: width of the packet byte-length input.

- clk  in  1  clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request one packet; sampled only in IDLE.
- pkt_len  in  LEN_WIDTH  packet length in bytes; latched with start.
- first_byte  in  8  value of payload byte 0; latched with start.
- busy  out  1  high while a packet is in progress (SEND).
- done  out  1  one-cycle pulse after the last beat's handshake.
- m_axis_tready  in  1  sink ready.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tdata  out  DATA_WIDTH  beat data.
- m_axis_tkeep  out  BYTES  byte-lane qualifiers.
- m_axis_tlast  out  1  last beat of packet.

## Operation
- States: IDLE, SEND.
  - IDLE -> SEND: on start=1 and pkt_len!=0.
  - SEND -> IDLE: on handshake (tvalid && tready) of the beat with tlast=1.
- start with pkt_len=0: ignored; no beats and no done.
- start while in SEND: ignored, including the cycle of the final handshake.
- On the IDLE->SEND edge, latch:
  - bytes_left = pkt_len
  - next_byte = first_byte
- Beats per packet = ceil(pkt_len/BYTES).
- Beat contents:
  - Lane k (bits 8k+7:8k) carries payload byte (beat_index*BYTES + k).
  - Payload byte i = (first_byte + i) mod 256, so the value wraps 0xFF -> 0x00.
- Full beat (bytes_left > BYTES): tkeep all ones, tlast=0.
- Last beat (bytes_left <= BYTES):
  - tkeep low bytes_left bits set, contiguous from lane 0.
  - tlast=1.
  - Unused lanes of tdata are driven 0.
- On each handshake:
  - bytes_left -= BYTES (the last beat takes it to or past zero and ends the packet).
  - next_byte += BYTES (mod 256).
- Backpressure: while tvalid=1 and tready=0, tdata/tkeep/tlast are held stable and tvalid stays 1; no output changes until the handshake.
- tvalid never depends combinationally on tready; all outputs are registered.
- busy = (state==SEND).
- done: registered; high exactly one cycle, the cycle after the final handshake (coincides with the first IDLE cycle).

## Timing
- Reset (async assert): state=IDLE; tvalid=0, tlast=0, tkeep=0, tdata=0, busy=0, done=0; counters cleared.
- Reset mid-packet: packet abandoned, tvalid drops at once with no tlast. After release the block is in IDLE and needs a new start.
- Latency: start sampled at edge N -> tvalid=1 and busy=1 from cycle N+1.
- Throughput: one beat per cycle while tready=1.
- Final handshake at edge M -> tvalid=0 and done=1 in cycle M+1.
- Back-to-back: a start sampled at edge M+1 (done cycle) is accepted. Its first beat is valid in cycle M+2, giving a minimum 1-cycle gap between packets.
- pkt_len/first_byte changes during SEND have no effect on the current packet.

## Test plan
- DATA_WIDTH=32, pkt_len=10, first_byte=0x10, tready=1 -> 3 consecutive beats:
  - 0x13121110 / keep 0xF
  - 0x17161514 / keep 0xF
  - 0x00001918 / keep 0x3 / tlast=1
  - done pulses one cycle after the third beat.
- Same packet with tready toggling 1,0,0,1,0,1 -> identical beat sequence; outputs stable during every tready=0 cycle; tvalid never deasserts mid-packet.
- pkt_len=4, first_byte=0xFE -> single beat 0x0100FFFE, keep 0xF, tlast=1 (exact-fit beat and byte wraparound).
- pkt_len=0 with start=1 -> tvalid, busy and done stay 0.
- start=1 held continuously, pkt_len=8 -> packets separated by exactly one idle cycle. start pulses during SEND do not add packets or restart the count.
- reset asserted after beat 1 of a 12-byte packet -> tvalid/busy/tlast go 0 immediately. A new start after release produces a full fresh packet beginning at first_byte.
